bta_operand_loader: RTL and testbench
=====================================

Name: bta_operand_loader

Overview:
- Upstream feeder and result collector for the 8-operand, 32-slice binary tree adder.
- Accepts operands serially, one per cycle, over a valid/ready stream and packs them into eight parallel operand registers (A..H).
- Presents the registers to the tree adder, waits the adder's fixed pipeline latency, then captures the sum.
- Returns the sum over an output valid/ready handshake.

Parameters:
- N, 32, tree-adder width parameter; sets sum growth to $clog2(N) bits.
- M, 16, operand width in bits.
- LAT, 2, tree-adder latency in clk cycles from op_valid to a stable sum_in (legal range 1..15).

Ports:
- clk  input  1  system clock; all logic is on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  an operand is present on in_data.
- in_ready  output  1  loader can accept an operand this cycle.
- in_data  input  M  operand value.
- op_a..op_h  output  M each  operand registers; op_a is the 1st operand accepted, op_h the 8th.
- op_cin  output  1  carry-in to the tree adder; constant 0.
- op_valid  output  1  one-cycle pulse marking that op_a..op_h are newly complete.
- sum_in  input  M+$clog2(N)  sum returned by the tree adder.
- res_valid  output  1  res_data holds a captured sum.
- res_ready  input  1  downstream accepts res_data.
- res_data  output  M+$clog2(N)  captured sum.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=FILL, slot counter=0, wait counter=0.
  - op_a..op_h=0, res_data=0, op_valid=0, res_valid=0, in_ready=1 in the following cycle.
  - Reset overrides every state, including mid-FILL, WAIT and HOLD. Partially loaded operands are discarded, and a pending result is dropped without a handshake.
- FSM states: FILL, ISSUE, WAIT, HOLD.
- FILL:
  - in_ready=1.
  - On in_valid&in_ready, in_data is written to the slot indexed by the counter (0=op_a ... 7=op_h) and the counter increments.
  - Cycles with in_valid=0 change nothing; gaps are legal.
  - On acceptance of the 8th operand (counter==7): counter wraps to 0 and the next state is ISSUE.
- ISSUE:
  - Lasts exactly one cycle; op_valid=1, in_ready=0.
  - Next state is WAIT, with the wait counter loaded to LAT-1.
- WAIT:
  - in_ready=0; op_a..op_h held stable.
  - The wait counter decrements each cycle.
  - In the cycle the counter is 0: sum_in is registered into res_data, res_valid is set, and the next state is HOLD.
  - Sum latency: first sample of sum_in occurs LAT cycles after the op_valid cycle.
- HOLD:
  - res_valid=1; res_data and op_a..op_h held stable; in_ready=0.
  - On res_ready=1, res_valid clears next cycle and the next state is FILL.
  - Operands for the next batch are not accepted in the handshake cycle; the first new operand is accepted one cycle later.
- Minimum batch period: 8 FILL + 1 ISSUE + LAT WAIT + 1 HOLD cycles.
- Operand registers:
  - Retain the previous batch's values until overwritten slot by slot; they are not cleared between batches.
  - The tree adder samples only on op_valid and the following LAT cycles.
- Arithmetic:
  - The loader does no arithmetic; res_data is sum_in passed through unchanged at full width.
  - Expected value: sum of the 8 operands, zero-extended to M+$clog2(N) bits; the maximum 8*(2^M-1) never overflows.
- Handshake rules:
  - in_valid/in_data may change arbitrarily while in_ready=0; nothing is captured.
  - res_ready=1 outside HOLD is ignored.
- op_cin is tied 0 in all states.

Test Plan:
- Reset, then operands 1,2,3,4,5,6,7,8 back-to-back with res_ready=1 -> op_valid pulses exactly 1 cycle after the 8th acceptance; op_a=1 ... op_h=8; res_valid rises LAT+1 cycles after op_valid; res_data=36 (0x00024).
- Eight operands of 0xFFFF -> res_data=0x7FFF8; no truncation across the 21-bit width.
- in_valid toggled 1,0,0,1,... with operands 10,20,...,80 -> slots fill only on handshake cycles; res_data=360; in_ready=0 from ISSUE until one cycle after the result handshake.
- res_ready held 0 for 5 cycles in HOLD -> res_valid and res_data stay constant and in_ready=0 throughout; the result completes on the cycle res_ready=1; the next batch of 8x100 yields 800.
- rst asserted after 5 operands, then a fresh batch 1..8 -> outputs reset to 0; the new batch fills op_a first; res_data=36, with no contribution from the stale operands.
- rst asserted during WAIT and again during HOLD -> no res_valid pulse and state=FILL; in_ready=1 in the following cycle.

Source files
------------

// File: rtl/bta_operand_loader_if.sv
// Signal bundle between the operand loader, the stream source, the tree adder and the result sink.
// The master modport is the loader's view; the slave modport is the surrounding environment's view.
interface bta_operand_loader_if #(
  parameter int N = 32,
  parameter int M = 16
);
  localparam int SW = M + $clog2(N);

  logic          in_valid;
  logic          in_ready;
  logic [M-1:0]  in_data;
  logic [M-1:0]  op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h;
  logic          op_cin;
  logic          op_valid;
  logic [SW-1:0] sum_in;
  logic          res_valid;
  logic          res_ready;
  logic [SW-1:0] res_data;

  modport master (
    input  in_valid, in_data, sum_in, res_ready,
    output in_ready, op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h,
           op_cin, op_valid, res_valid, res_data
  );

  modport slave (
    output in_valid, in_data, sum_in, res_ready,
    input  in_ready, op_a, op_b, op_c, op_d, op_e, op_f, op_g, op_h,
           op_cin, op_valid, res_valid, res_data
  );
endinterface

// File: rtl/bta_operand_loader.sv
// Packs eight serially streamed operands into parallel registers for the tree adder,
// waits out the adder's fixed latency, and hands the captured sum downstream.
module bta_operand_loader #(
  parameter int N   = 32,
  parameter int M   = 16,
  parameter int LAT = 2
) (
  input logic                clk,
  input logic                rst,
  bta_operand_loader_if.master bus
);
  localparam int SW = M + $clog2(N);
  localparam logic [3:0] WAIT_INIT = 4'(LAT - 1);

  typedef enum logic [1:0] {FILL, ISSUE, WAIT, HOLD} state_t;

  state_t        state_q;
  logic [2:0]    slot_q;
  logic [3:0]    wait_q;
  logic [M-1:0]  ops_q [8];
  logic [SW-1:0] res_data_q;
  logic          op_valid_q;
  logic          res_valid_q;
  logic          in_ready_q;

  assign bus.op_a      = ops_q[0];
  assign bus.op_b      = ops_q[1];
  assign bus.op_c      = ops_q[2];
  assign bus.op_d      = ops_q[3];
  assign bus.op_e      = ops_q[4];
  assign bus.op_f      = ops_q[5];
  assign bus.op_g      = ops_q[6];
  assign bus.op_h      = ops_q[7];
  assign bus.op_cin    = 1'b0;
  assign bus.op_valid  = op_valid_q;
  assign bus.in_ready  = in_ready_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= FILL;
      slot_q      <= '0;
      wait_q      <= '0;
      for (int i = 0; i < 8; i++) ops_q[i] <= '0;
      res_data_q  <= '0;
      op_valid_q  <= 1'b0;
      res_valid_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      op_valid_q <= 1'b0;
      unique case (state_q)
        FILL: begin
          // slot_q wraps 7 -> 0 on its own, leaving it ready for the next batch
          if (bus.in_valid) begin
            ops_q[slot_q] <= bus.in_data;
            slot_q        <= slot_q + 3'd1;
            if (slot_q == 3'd7) begin
              state_q    <= ISSUE;
              op_valid_q <= 1'b1;
              in_ready_q <= 1'b0;
            end
          end
        end
        ISSUE: begin
          state_q <= WAIT;
          wait_q  <= WAIT_INIT;
        end
        WAIT: begin
          if (wait_q == 4'd0) begin
            res_data_q  <= bus.sum_in;
            res_valid_q <= 1'b1;
            state_q     <= HOLD;
          end else begin
            wait_q <= wait_q - 4'd1;
          end
        end
        HOLD: begin
          // in_ready rises the cycle after the handshake, so no operand is taken in it
          if (bus.res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= FILL;
          end
        end
        default: state_q <= FILL;
      endcase
    end
  end
endmodule

// File: tb/tb_bta_operand_loader.sv
// Directed bench for bta_operand_loader: a cycle-stamped behavioural model checked every cycle,
// a latency-accurate tree-adder stand-in, and literal expectations for each scenario.
module tb_bta_operand_loader;
  localparam int N   = 32;
  localparam int M   = 16;
  localparam int LAT = 2;
  localparam int SW  = M + $clog2(N);

  logic clk;
  logic rst;
  int   checks   = 0;
  int   failures = 0;

  bta_operand_loader_if #(.N(N), .M(M)) ifc ();

  bta_operand_loader #(.N(N), .M(M), .LAT(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (ifc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Tree adder stand-in: the sum is only correct exactly LAT cycles after op_valid
  logic [SW-1:0] adder_sum;
  logic [SW-1:0] pipe [LAT];
  always_comb begin
    adder_sum = SW'(ifc.op_a) + SW'(ifc.op_b) + SW'(ifc.op_c) + SW'(ifc.op_d)
              + SW'(ifc.op_e) + SW'(ifc.op_f) + SW'(ifc.op_g) + SW'(ifc.op_h);
  end
  always_ff @(posedge clk) begin
    pipe[0] <= ifc.op_valid ? adder_sum : '1;
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
  end
  assign ifc.sum_in = pipe[LAT-1];

  logic [M-1:0] dut_ops [8];
  always_comb begin
    dut_ops[0] = ifc.op_a; dut_ops[1] = ifc.op_b; dut_ops[2] = ifc.op_c; dut_ops[3] = ifc.op_d;
    dut_ops[4] = ifc.op_e; dut_ops[5] = ifc.op_f; dut_ops[6] = ifc.op_g; dut_ops[7] = ifc.op_h;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Behavioural model: cyc numbers clock edges; the cycle after edge n is cycle n.
  int           cyc = 0;
  bit           m_init = 0;
  bit           m_busy = 0;
  int           m_cnt = 0;
  int           m_t8 = -100;
  int           m_sum = 0;
  int           m_res = 0;
  logic [M-1:0] m_ops [8];

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      if (rst) begin
        m_init = 1;
        for (int i = 0; i < 8; i++) m_ops[i] = '0;
        m_cnt  = 0;
        m_busy = 0;
        m_res  = 0;
      end else if (m_init) begin
        if (!m_busy) begin
          if (ifc.in_valid) begin
            m_ops[m_cnt] = ifc.in_data;
            m_cnt++;
            if (m_cnt == 8) begin
              m_cnt  = 0;
              m_busy = 1;
              m_t8   = cyc;
              m_sum  = 0;
              for (int i = 0; i < 8; i++) m_sum += int'(m_ops[i]);
            end
          end
        end else if ((cyc - 1) >= m_t8 + LAT + 1 && ifc.res_ready) begin
          m_busy = 0;
        end
        if (m_busy && cyc == m_t8 + LAT + 1) m_res = m_sum;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (m_init) begin
        chk("in_ready",  32'(ifc.in_ready),  32'(!m_busy));
        chk("op_valid",  32'(ifc.op_valid),  32'(m_busy && cyc == m_t8));
        chk("res_valid", 32'(ifc.res_valid), 32'(m_busy && cyc >= m_t8 + LAT + 1));
        chk("res_data",  32'(ifc.res_data),  32'(m_res));
        chk("op_cin",    32'(ifc.op_cin),    32'd0);
        for (int i = 0; i < 8; i++) chk($sformatf("op%0d", i), 32'(dut_ops[i]), 32'(m_ops[i]));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [M-1:0] d);
    int   n;
    logic r;
    n = 0;
    ifc.in_valid = 1'b1;
    ifc.in_data  = d;
    do begin
      @(negedge clk);
      r = ifc.in_ready;
      step();
      n++;
    end while (!r && n < 64);
    chk("send_accepted", 32'(r), 32'd1);
    ifc.in_valid = 1'b0;
    ifc.in_data  = M'($urandom);
  endtask

  task automatic wait_res(input string name, output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!ifc.res_valid && k < 64);
    chk({name, "_seen"}, 32'(ifc.res_valid), 32'd1);
  endtask

  int k;

  initial begin
    rst           = 1'b1;
    ifc.in_valid  = 1'b0;
    ifc.in_data   = '0;
    ifc.res_ready = 1'b1;
    step();
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready",  32'(ifc.in_ready),  32'd1);
    chk("rst_op_a",      32'(ifc.op_a),      32'd0);
    chk("rst_op_valid",  32'(ifc.op_valid),  32'd0);
    chk("rst_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("rst_res_data",  32'(ifc.res_data),  32'd0);
    step();

    // Back-to-back 1..8
    for (int i = 1; i <= 8; i++) send(M'(i));
    @(negedge clk);
    chk("t1_op_valid", 32'(ifc.op_valid), 32'd1);
    chk("t1_op_a", 32'(ifc.op_a), 32'd1);
    chk("t1_op_d", 32'(ifc.op_d), 32'd4);
    chk("t1_op_h", 32'(ifc.op_h), 32'd8);
    wait_res("t1", k);
    chk("t1_res_latency", 32'(k), 32'(LAT + 1));
    chk("t1_res_data", 32'(ifc.res_data), 32'h00024);
    step();

    // Full-scale operands
    for (int i = 0; i < 8; i++) send(16'hFFFF);
    wait_res("t2", k);
    chk("t2_res_data", 32'(ifc.res_data), 32'h7FFF8);
    step();

    // Gapped stream 10..80
    for (int i = 1; i <= 8; i++) begin
      send(M'(10 * i));
      if (i < 8) begin step(); step(); end
    end
    @(negedge clk);
    chk("t3_issue_ready", 32'(ifc.in_ready), 32'd0);
    wait_res("t3", k);
    chk("t3_res_data", 32'(ifc.res_data), 32'd360);
    chk("t3_hold_ready", 32'(ifc.in_ready), 32'd0);
    step();
    @(negedge clk);
    chk("t3_ready_after", 32'(ifc.in_ready), 32'd1);
    step();

    // Back-pressure in HOLD
    ifc.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(M'(50));
    wait_res("t4", k);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t4_hold_valid", 32'(ifc.res_valid), 32'd1);
      chk("t4_hold_data",  32'(ifc.res_data),  32'd400);
      chk("t4_hold_ready", 32'(ifc.in_ready),  32'd0);
    end
    step();
    ifc.res_ready = 1'b1;
    step();
    @(negedge clk);
    chk("t4_res_cleared", 32'(ifc.res_valid), 32'd0);
    chk("t4_ready_back",  32'(ifc.in_ready),  32'd1);
    step();
    for (int i = 0; i < 8; i++) send(M'(100));
    wait_res("t4b", k);
    chk("t4b_res_data", 32'(ifc.res_data), 32'd800);
    step();

    // Reset mid-FILL
    for (int i = 0; i < 5; i++) send(M'(9));
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t5_op_a_clr", 32'(ifc.op_a), 32'd0);
    chk("t5_op_e_clr", 32'(ifc.op_e), 32'd0);
    chk("t5_ready",    32'(ifc.in_ready), 32'd1);
    step();
    for (int i = 1; i <= 8; i++) send(M'(i));
    @(negedge clk);
    chk("t5_op_a", 32'(ifc.op_a), 32'd1);
    wait_res("t5", k);
    chk("t5_res_data", 32'(ifc.res_data), 32'd36);
    step();

    // Reset during WAIT
    for (int i = 1; i <= 8; i++) send(M'(i));
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    for (int i = 0; i < LAT + 3; i++) begin
      @(negedge clk);
      chk("t6_wait_no_res", 32'(ifc.res_valid), 32'd0);
      chk("t6_wait_ready",  32'(ifc.in_ready),  32'd1);
    end
    step();

    // Reset during HOLD
    ifc.res_ready = 1'b0;
    for (int i = 0; i < 8; i++) send(M'(7));
    wait_res("t6h", k);
    chk("t6h_res_data", 32'(ifc.res_data), 32'd56);
    step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    @(negedge clk);
    chk("t6h_res_valid", 32'(ifc.res_valid), 32'd0);
    chk("t6h_res_data0", 32'(ifc.res_data),  32'd0);
    chk("t6h_ready",     32'(ifc.in_ready),  32'd1);
    ifc.res_ready = 1'b1;
    step();
    for (int i = 1; i <= 8; i++) send(M'(i));
    wait_res("t6r", k);
    chk("t6r_res_data", 32'(ifc.res_data), 32'd36);
    step();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
